// File: rtl/fetch_if.sv
// Fetch controller bus: PC control, instruction memory port
// and IF/ID output buffer signals.
interface fetch_if;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    input  pc, stall_i,
    input  redirect_valid, redirect_pc,
    input  trap_valid, trap_pc,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  if_ready,
    output next_pc, pc_en,
    output imem_req, imem_addr,
    output if_valid, if_pc, if_instr
  );

  modport slave (
    output pc, stall_i,
    output redirect_valid, redirect_pc,
    output trap_valid, trap_pc,
    output imem_gnt, imem_rvalid, imem_rdata,
    output if_ready,
    input  next_pc, pc_en,
    input  imem_req, imem_addr,
    input  if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC advance, single-outstanding imem
// fetch, redirect handling and one-entry IF/ID buffer.
module fetch_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic        drop;
  logic [31:0] req_pc;
  logic        redir;
  logic        buf_ok;
  logic        fire;
  logic        load;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;

  assign redir   = bus.trap_valid | bus.redirect_valid;
  assign tgt_raw = bus.trap_valid ? bus.trap_pc
                                  : bus.redirect_pc;
  assign tgt     = tgt_raw & ~32'd3;
  assign buf_ok  = !bus.if_valid | bus.if_ready;

  assign bus.imem_req  = (state == REQ) & !bus.stall_i
                       & buf_ok & !redir;
  assign bus.imem_addr = bus.pc;

  assign fire = bus.imem_req & bus.imem_gnt;
  assign load = (state == WAIT) & bus.imem_rvalid
              & !drop & !redir;

  always_comb begin
    bus.pc_en   = redir | fire;
    bus.next_pc = redir ? tgt : bus.pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      drop         <= 1'b0;
      req_pc       <= 32'd0;
      bus.if_valid <= 1'b0;
      bus.if_pc    <= 32'd0;
      bus.if_instr <= NOP_INSTR;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (fire) begin
            req_pc <= bus.pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            drop  <= 1'b0;
            state <= REQ;
          end else if (redir) begin
            drop  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // flush beats reload, reload beats consume
      if (redir) begin
        bus.if_valid <= 1'b0;
        bus.if_instr <= NOP_INSTR;
      end else if (load) begin
        bus.if_valid <= 1'b1;
        bus.if_pc    <= req_pc;
        bus.if_instr <= bus.imem_rdata;
      end else if (bus.if_valid & bus.if_ready) begin
        bus.if_valid <= 1'b0;
        bus.if_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a
// transaction-level reference of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if bus ();

  fetch_ctrl #(.NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] pc_r, p_next;
  bit          p_en;
  bit          m_bv;
  logic [31:0] m_bpc, m_binstr;
  bit          out_q, stale;
  int          cnt, lat;
  logic [31:0] rsp_addr, exp_pc;

  bit          s_req, s_pc_en, s_ifv;
  logic [31:0] s_addr, s_next, s_ifpc, s_ifinstr;
  logic [31:0] req_q[$];
  logic [31:0] cons_q[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.imem_gnt       = 1'b0;
    bus.if_ready       = 1'b0;
    bus.stall_i        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.trap_valid     = 1'b0;
    bus.trap_pc        = 32'd0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'd0;
    bus.pc             = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_instr", bus.if_instr, NOP);
    @(negedge clk);
    rst    = 1'b0;
    pc_r   = 32'd0;
    p_en   = 1'b0;
    m_bv   = 1'b0;
    out_q  = 1'b0;
    stale  = 1'b0;
    exp_pc = 32'd0;
    #1;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
  endtask

  task automatic cyc(input bit g, input bit rdy,
                     input bit stl, input bit rv,
                     input logic [31:0] rpc, input bit tv,
                     input logic [31:0] tpc);
    logic [31:0] traw, tgt;
    bit redir, deliver, e_req, grant, good;
    @(negedge clk);
    if (p_en) pc_r = p_next;
    deliver = out_q && (cnt == 0);
    bus.pc             = pc_r;
    bus.imem_gnt       = g;
    bus.if_ready       = rdy;
    bus.stall_i        = stl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.trap_valid     = tv;
    bus.trap_pc        = tpc;
    bus.imem_rvalid    = deliver;
    bus.imem_rdata     = deliver ? memw(rsp_addr) : $urandom;
    #1;
    redir = rv | tv;
    traw  = tv ? tpc : rpc;
    tgt   = {traw[31:2], 2'b00};
    e_req = !out_q && !stl && (!m_bv || rdy) && !redir;
    grant = e_req && g;
    chk("req", 32'(bus.imem_req), 32'(e_req));
    chk("addr", bus.imem_addr, pc_r);
    chk("pc_en", 32'(bus.pc_en), 32'(redir | grant));
    if (redir | grant)
      chk("next_pc", bus.next_pc, redir ? tgt : pc_r + 32'd4);
    chk("if_valid", 32'(bus.if_valid), 32'(m_bv));
    if (m_bv) begin
      chk("if_pc", bus.if_pc, m_bpc);
      chk("if_instr", bus.if_instr, m_binstr);
    end
    s_req = bus.imem_req;  s_addr = bus.imem_addr;
    s_pc_en = bus.pc_en;   s_next = bus.next_pc;
    s_ifv = bus.if_valid;  s_ifpc = bus.if_pc;
    s_ifinstr = bus.if_instr;
    if (bus.imem_req) req_q.push_back(bus.imem_addr);
    // in-order stream: each consumed word follows the last
    if (m_bv && rdy) begin
      cons_q.push_back(bus.if_pc);
      chk("stream_pc", bus.if_pc, exp_pc);
      chk("stream_instr", bus.if_instr, memw(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    p_en   = bus.pc_en;
    p_next = bus.next_pc;
    good = deliver && !stale && !redir;
    if (redir) m_bv = 1'b0;
    else if (good) begin
      m_bv = 1'b1; m_bpc = rsp_addr; m_binstr = memw(rsp_addr);
    end else if (m_bv && rdy) m_bv = 1'b0;
    if (deliver) begin
      out_q = 1'b0; stale = 1'b0;
    end else if (out_q) begin
      if (redir) stale = 1'b1;
      cnt--;
    end
    if (grant) begin
      out_q    = 1'b1;
      rsp_addr = pc_r;
      cnt      = (lat == 0) ? int'($urandom_range(0, 2)) : lat - 1;
    end
    if (redir) exp_pc = tgt;
  endtask

  initial begin
    logic [31:0] a;
    int vcnt;
    bit found;
    drive_idle();
    lat = 1;

    // reset release, streaming 0,4,8
    do_reset();
    req_q.delete(); cons_q.delete();
    repeat (8) cyc(1, 1, 0, 0, 0, 0, 0);
    chk("seq_nreq", 32'(req_q.size() >= 3), 32'd1);
    chk("seq_addr0", req_q[0], 32'h0);
    chk("seq_addr1", req_q[1], 32'h4);
    chk("seq_addr2", req_q[2], 32'h8);
    chk("seq_cons0", cons_q[0], 32'h0);
    chk("seq_cons1", cons_q[1], 32'h4);
    chk("seq_cons2", cons_q[2], 32'h8);

    // backpressure with PC 4 held in the buffer
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      found = s_req && (s_addr == 32'h4);
    end
    chk("bp_timeout", 32'(found), 32'd1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("bp_req", 32'(s_req), 32'd0);
      chk("bp_hold_pc", s_ifpc, 32'h4);
    end
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("bp_resume_req", 32'(s_req), 32'd1);
    chk("bp_resume_addr", s_addr, 32'h8);

    // redirect while a fetch is outstanding
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      found = s_req;
    end
    chk("rd_timeout", 32'(found), 32'd1);
    cyc(1, 1, 0, 1, 32'h100, 0, 0);
    chk("rd_pc_en", 32'(s_pc_en), 32'd1);
    chk("rd_next_pc", s_next, 32'h100);
    found = 1'b0; vcnt = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      found = s_req;
      if (s_ifv) vcnt++;
    end
    chk("rd_req_timeout", 32'(found), 32'd1);
    chk("rd_new_addr", s_addr, 32'h100);
    chk("rd_no_stale", 32'(vcnt), 32'd0);

    // trap wins over branch, buffer flushed
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      found = s_ifv;
    end
    chk("tr_timeout", 32'(found), 32'd1);
    cyc(0, 0, 0, 1, 32'h100, 1, 32'h200);
    chk("tr_next_pc", s_next, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("tr_flush_v", 32'(s_ifv), 32'd0);
    chk("tr_flush_nop", s_ifinstr, NOP);

    // stall in REQ
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      found = s_req;
    end
    a = s_addr;
    chk("st_addr", a, 32'h200);
    repeat (3) begin
      cyc(1, 1, 1, 0, 0, 0, 0);
      chk("st_req", 32'(s_req), 32'd0);
      chk("st_pc_en", 32'(s_pc_en), 32'd0);
    end
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("st_resume_req", 32'(s_req), 32'd1);
    chk("st_resume_addr", s_addr, a);

    // PC wrap at top of address space
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      found = s_req;
    end
    chk("wr_addr", s_addr, 32'hFFFF_FFFC);
    chk("wr_pc_en", 32'(s_pc_en), 32'd1);
    chk("wr_next_pc", s_next, 32'h0);
    repeat (4) cyc(1, 1, 0, 0, 0, 0, 0);

    // misaligned target
    cyc(0, 1, 0, 1, 32'h103, 0, 0);
    chk("mis_next_pc", s_next, 32'h100);

    // random traffic, with a reset in the middle
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 19) == 0, $urandom,
          $urandom_range(0, 39) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the program counter register and the instruction-memory port. It decides when the PC advances and to what value, drives `pc_en`/`next_pc`, and issues single-outstanding instruction fetches. It also applies branch and trap redirects, discards stale responses after a redirect, and presents fetched instructions to the IF/ID boundary through a one-entry output buffer with a valid/ready handshake.

## Interface
- `NOP_INSTR`, default 32'h00000013: value driven on `if_instr` at reset and after a flush.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pc` in 32: current PC from the PC register.
- `next_pc` out 32: value the PC register loads when `pc_en` is high.
- `pc_en` out 1: PC register load enable.
- `stall_i` in 1: hazard stall; blocks new fetch requests.
- `redirect_valid` in 1: branch/jump redirect from EX.
- `redirect_pc` in 32: redirect target.
- `trap_valid` in 1: trap/return redirect; has priority over `redirect_valid`.
- `trap_pc` in 32: trap target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid. The earliest response is the cycle after grant.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: output buffer holds an instruction.
- `if_pc` out 32: PC of the buffered instruction.
- `if_instr` out 32: buffered instruction.
- `if_ready` in 1: downstream consumes the buffer this cycle.

## Operation
- State machine states:
  - IDLE: entered on reset; goes to REQ unconditionally on the next cycle.
  - REQ: waiting to issue or be granted.
  - WAIT: one fetch outstanding.
- Internal flag `drop`: the outstanding response is stale.
- Redirect target: `tgt = trap_valid ? trap_pc : redirect_pc`. It applies when `redir = trap_valid | redirect_valid`. Bits [1:0] of `tgt` are forced to 0.
- Buffer free condition: `buf_ok = !if_valid | if_ready`.
- `imem_req = (state==REQ) & !stall_i & buf_ok & !redir`. This is combinational and is 0 in IDLE and during reset.
- PC control (combinational), in priority order:
  - If `redir`: `pc_en=1`, `next_pc=tgt`.
  - Else if `imem_req & imem_gnt`: `pc_en=1`, `next_pc=pc+4`. Addition is mod 2^32, so 32'hFFFFFFFC wraps to 0.
  - Otherwise `pc_en=0` and `next_pc=pc+4` (don't-care).
- REQ: on `imem_req & imem_gnt`, latch `pc` as the request PC and go to WAIT. Otherwise stay in REQ.
- WAIT, `imem_rvalid` high:
  - If `drop` is set, or `redir` is high the same cycle: discard the data, clear `drop`, go to REQ.
  - Otherwise load the buffer: `if_valid=1`, `if_pc` = request PC, `if_instr=imem_rdata`, then go to REQ.
- WAIT, `imem_rvalid` low: on `redir`, set `drop` and stay in WAIT.
- Buffer:
  - Cleared (`if_valid=0`, `if_instr=NOP_INSTR`) on the cycle after `redir`.
  - Cleared on the cycle after `if_valid & if_ready` unless reloaded that cycle. A reload takes precedence over consume-clear.
  - `redir` flush takes precedence over any reload.
- Because a request is granted only when `buf_ok` holds, the buffer is always free when a response arrives. No response is lost.
- `stall_i` does not affect an outstanding fetch or buffer contents.

## Timing
- Reset values:
  - state IDLE, `drop=0`.
  - `if_valid=0`, `if_pc=0`, `if_instr=NOP_INSTR`.
  - `imem_req=0`, `pc_en=0`.
- First `imem_req` is in the second cycle after `rst` deasserts: cycle 0 is IDLE, cycle 1 is REQ.
- With single-cycle grant and a response one cycle later, throughput is one instruction per 2 cycles. `if_valid` rises the cycle after `imem_rvalid`.
- A redirect takes effect in the same cycle via `pc_en`. The first request to the target is issued the next cycle if no fetch is outstanding. Otherwise it is issued after the stale response is discarded.
- Reset mid-fetch: all state clears immediately, and the pending response is ignored because state is IDLE.

## Test plan
- Reset release, with `imem_gnt=1` every cycle and `imem_rvalid` one cycle after each grant:
  - `imem_addr` sequence 0, 4, 8.
  - `if_pc` 0, 4, 8 with matching `if_instr`.
  - `pc_en` high exactly on grant cycles.
- Backpressure, with `if_ready=0` while `if_valid=1` and `if_pc=4`:
  - `imem_req` stays 0 and the buffer holds.
  - After `if_ready=1` for one cycle, the request for PC 8 is issued that cycle.
- Redirect while WAIT, with `redirect_pc=32'h100` and the response arriving 2 cycles later:
  - `next_pc=32'h100`, `pc_en=1`.
  - The stale response is dropped, with no `if_valid` for it.
  - The next `imem_addr` is 32'h100.
- Simultaneous `trap_valid` (`trap_pc=32'h200`) and `redirect_valid` (32'h100):
  - `next_pc=32'h200`.
  - The buffer is flushed to `NOP_INSTR`.
- `stall_i=1` for 3 cycles in REQ: no `imem_req` and no `pc_en`. Fetch resumes at the same PC afterward.
- PC at 32'hFFFFFFFC granted: `next_pc=32'h00000000`.
- Misaligned `redirect_pc=32'h103`: `next_pc=32'h100`.
